id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Next-generation decode/operand stage for the 16-bit pipelined core, generalised in data width and register count.
- Holds the register file, forms the two ALU sources and the store data.
- Owns the ID/EX pipeline register, with a valid/ready handshake on each side.
- Tracks in-flight register writes with a per-register pending scoreboard, and stalls fetch on read-after-write hazards.
- Accepts a flush from branch resolution.

Parameters:
DATA_W, 16, datapath/register width
REG_CNT, 8, number of architectural registers
ADDR_W, 3, register address width (2**ADDR_W >= REG_CNT)
CTL_W, 8, width of opaque EX/MEM/WB control bundle passed through
PEND_W, 2, width of per-register pending-write counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  fetch presents a decoded instruction
in_ready  out  1  stage accepts instruction this cycle (combinational)
rs_addr  in  ADDR_W  source 0 register
rt_addr  in  ADDR_W  source 1 / store-data register
rd_addr  in  ADDR_W  destination register
use_rs  in  1  instruction reads rs
use_rt  in  1  instruction reads rt
rf_wr  in  1  instruction will write rd at WB
imm  in  DATA_W  pre-extended immediate
immregsel  in  1  1: src1 = imm, 0: src1 = rt
inv_src0  in  1  invert src0
inv_src1  in  1  invert src1
ctl_in  in  CTL_W  pass-through control
wb_wr  in  1  writeback write enable
wb_addr  in  ADDR_W  writeback register
wb_data  in  DATA_W  writeback data
flush  in  1  kill ID/EX contents and current input
ex_ready  in  1  EX consumes out_* this cycle
out_valid  out  1  ID/EX holds a live instruction
out_src0  out  DATA_W  registered ALU source 0
out_src1  out  DATA_W  registered ALU source 1
out_store  out  DATA_W  registered rt value (memory data_in)
out_rd  out  ADDR_W  registered destination
out_rf_wr  out  1  registered rf_wr
out_ctl  out  CTL_W  registered ctl_in
err  out  1  sticky error

Behaviour:
Reset:
- On rst at the clock edge: every register-file entry, every pending counter, all out_* and err go to 0.
- With rst deasserted and out_valid=0, in_ready=1, provided no hazard and no flush.

Register file:
- REG_CNT x DATA_W.
- Written at the clock edge when wb_wr=1 and wb_addr < REG_CNT.
- Reads are combinational.
- Read of an address >= REG_CNT returns 0.

Bypass:
- A read whose address equals wb_addr while wb_wr=1 returns wb_data in the same cycle.

Scoreboard:
- pend[r] counts accepted writers of r not yet written back.
- A source is busy if it is used, pend[addr] != 0, and it is not being written back this cycle. With the bypass, a pending count of exactly 1 that is being written back this cycle is not busy.
- hazard = busy(rs) | busy(rt) | (rf_wr & pend[rd] at max, with no wb to rd this cycle).

Handshake:
- free = !out_valid | ex_ready.
- in_ready = free & !hazard & !flush.
- accept = in_valid & in_ready.

Edge update:
- flush: out_valid <= 0.
- else if free: out_valid <= accept; payload loads on accept.
- else: all out_* hold.

Operands:
- out_src0 = inv_src0 ? ~rs : rs.
- out_src1 = inv_src1 ? ~(immregsel ? imm : rt) : (immregsel ? imm : rt).
- out_store = rt.

Counter updates per edge, netted on the same register:
- +1 on accept & rf_wr to rd.
- −1 on wb_wr to wb_addr.
- −1 on flush when out_valid & out_rf_wr, to out_rd.
- Result saturates at 0.

Error:
- err sets on wb_wr to an address >= REG_CNT.
- err sets on wb_wr to a register whose pend=0 and that is not simultaneously being incremented.
- err clears only on rst.

Optional Feature:
ID_WB_BYPASS_EN
- Defined: same-cycle WB-to-read bypass as above.
- Undefined: reads return stored contents only, and busy ignores same-cycle writeback. This costs one extra stall cycle on every RAW dependency resolved by WB.
- Scoreboard counting is unchanged in both builds.

Test Plan:
- Reset, then wb r3=0x1234 (pend was set by prior accept), then an instruction with rs=3, inv_src0=0 -> out_src0=0x1234, out_valid=1, err=0.
- Accept instruction A writing r2; present B using rt=r2 -> in_ready=0 until wb_wr r2=0x00FF. With bypass, B is accepted that same cycle and out_src1=0x00FF; without bypass, B is accepted one cycle later.
- immregsel=1, imm=0x0005, inv_src1=1 -> out_src1=0xFFFA. inv_src0=1 with rs=0x0000 -> out_src0=0xFFFF.
- ex_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0. ex_ready=1 -> next instruction loads.
- flush while ID/EX holds a writer to r5 (pend[5]=1) -> out_valid=0 next cycle, pend[5]=0, a subsequent reader of r5 is not stalled.
- wb_wr to r6 with pend[6]=0 -> err=1, which persists until rst. With PEND_W=2, accepting a 4th writer to r1 without writebacks -> in_ready=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode/operand stage of the pipelined core.
//   - REG_CNT x DATA_W register file with combinational reads.
//   - Per-register pending-write scoreboard that stalls fetch on RAW
//     hazards and on pending-counter overflow.
//   - ID/EX pipeline register with a valid/ready handshake on both sides.
// Optional feature macro: ID_WB_BYPASS_EN
//   defined   : a read of the register being written back this cycle
//               returns wb_data, and that writeback can clear a hazard
//               in the same cycle.
//   undefined : reads return stored contents only; a dependency resolved
//               by WB is released one cycle later.
//
// Handshake (both sides): a transfer happens on a clock edge where valid
// and ready are both high. Upstream: in_valid/in_ready, where in_ready is
// combinational and never depends on in_valid. Downstream: out_valid/ex_ready;
// while out_valid=1 and ex_ready=0 every out_* holds its value. flush
// overrides both sides: the ID/EX slot is emptied and nothing is accepted.
module id_stage_pipe #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3,
  parameter int CTL_W   = 8,
  parameter int PEND_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              rf_wr,
  input  logic [DATA_W-1:0] imm,
  input  logic              immregsel,
  input  logic              inv_src0,
  input  logic              inv_src1,
  input  logic [CTL_W-1:0]  ctl_in,
  input  logic              wb_wr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_src0,
  output logic [DATA_W-1:0] out_src1,
  output logic [DATA_W-1:0] out_store,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rf_wr,
  output logic [CTL_W-1:0]  out_ctl,
  output logic              err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  // Architectural state.
  logic [DATA_W-1:0] rf       [REG_CNT];
  logic [PEND_W-1:0] pend     [REG_CNT];
  logic [PEND_W-1:0] pend_nxt [REG_CNT];

  // Register-file and scoreboard lookups for the current instruction.
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [PEND_W-1:0] rs_pend;
  logic [PEND_W-1:0] rt_pend;
  logic [PEND_W-1:0] rd_pend;
  logic [PEND_W-1:0] wb_pend;
  logic              wb_in_range;

  // Hazard and handshake terms.
  logic rs_wb_hit;
  logic rt_wb_hit;
  logic rd_wb_hit;
  logic rs_busy;
  logic rt_busy;
  logic rd_full;
  logic hazard;
  logic free;
  logic accept;
  logic err_set;

  // Operands presented to the ID/EX register.
  logic [DATA_W-1:0] src1_pre;
  logic [DATA_W-1:0] src0_d;
  logic [DATA_W-1:0] src1_d;

  // Decode every lookup by scanning the implemented registers, so any
  // address at or above REG_CNT naturally reads 0 with nothing pending.
  always_comb begin
    rs_val      = '0;
    rt_val      = '0;
    rs_pend     = '0;
    rt_pend     = '0;
    rd_pend     = '0;
    wb_pend     = '0;
    wb_in_range = 1'b0;
    for (int i = 0; i < REG_CNT; i++) begin
      if (rs_addr == ADDR_W'(i)) begin
        rs_val  = rf[i];
        rs_pend = pend[i];
      end
      if (rt_addr == ADDR_W'(i)) begin
        rt_val  = rf[i];
        rt_pend = pend[i];
      end
      if (rd_addr == ADDR_W'(i)) begin
        rd_pend = pend[i];
      end
      if (wb_addr == ADDR_W'(i)) begin
        wb_pend     = pend[i];
        wb_in_range = 1'b1;
      end
    end
`ifdef ID_WB_BYPASS_EN
    // Same-cycle forwarding of the value being written back.
    if (wb_wr && wb_in_range && (rs_addr == wb_addr)) begin
      rs_val = wb_data;
    end
    if (wb_wr && wb_in_range && (rt_addr == wb_addr)) begin
      rt_val = wb_data;
    end
`endif
  end

  assign rs_wb_hit = wb_wr && (wb_addr == rs_addr);
  assign rt_wb_hit = wb_wr && (wb_addr == rt_addr);
  assign rd_wb_hit = wb_wr && (wb_addr == rd_addr);

`ifdef ID_WB_BYPASS_EN
  // A source whose only outstanding writer retires this cycle is forwarded.
  assign rs_busy = use_rs && (rs_pend != '0) && !((rs_pend == PEND_ONE) && rs_wb_hit);
  assign rt_busy = use_rt && (rt_pend != '0) && !((rt_pend == PEND_ONE) && rt_wb_hit);
`else
  // Without forwarding the value only becomes readable after the edge.
  assign rs_busy = use_rs && (rs_pend != '0);
  assign rt_busy = use_rt && (rt_pend != '0);
`endif

  // A further writer cannot be counted while rd's counter is saturated,
  // unless a writeback to rd frees a slot on the same edge.
  assign rd_full = rf_wr && (rd_pend == PEND_MAX) && !rd_wb_hit;

  assign hazard   = rs_busy || rt_busy || rd_full;
  assign free     = !out_valid || ex_ready;
  assign in_ready = free && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // A writeback is unexpected if it targets a missing register or one with
  // no counted writer (a writer accepted on the same edge still counts).
  assign err_set = wb_wr &&
                   (!wb_in_range ||
                    ((wb_pend == '0) && !(accept && rf_wr && (rd_addr == wb_addr))));

  assign src1_pre = immregsel ? imm : rt_val;
  assign src0_d   = inv_src0 ? ~rs_val : rs_val;
  assign src1_d   = inv_src1 ? ~src1_pre : src1_pre;

  // Net the increment and both decrement sources per register; floor at 0.
  always_comb begin
    logic                inc;
    logic [1:0]          dec;
    logic [PEND_W:0]     sum;
    inc = 1'b0;
    dec = '0;
    sum = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      inc = accept && rf_wr && (rd_addr == ADDR_W'(i));
      dec = {1'b0, (wb_wr && (wb_addr == ADDR_W'(i)))} +
            {1'b0, (flush && out_valid && out_rf_wr && (out_rd == ADDR_W'(i)))};
      sum = {1'b0, pend[i]} + (PEND_W+1)'(inc);
      if (sum < (PEND_W+1)'(dec)) begin
        pend_nxt[i] = '0;
      end else begin
        pend_nxt[i] = PEND_W'(sum - (PEND_W+1)'(dec));
      end
    end
  end

  // Register file writes, scoreboard counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        rf[i]   <= '0;
        pend[i] <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int i = 0; i < REG_CNT; i++) begin
        if (wb_wr && (wb_addr == ADDR_W'(i))) begin
          rf[i] <= wb_data;
        end
        pend[i] <= pend_nxt[i];
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // ID/EX pipeline register: flush empties it, otherwise it refills
  // whenever the slot is free and holds while EX back-pressures.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_src0  <= '0;
      out_src1  <= '0;
      out_store <= '0;
      out_rd    <= '0;
      out_rf_wr <= 1'b0;
      out_ctl   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (free) begin
      out_valid <= accept;
      if (accept) begin
        out_src0  <= src0_d;
        out_src1  <= src1_d;
        out_store <= rt_val;
        out_rd    <= rd_addr;
        out_rf_wr <= rf_wr;
        out_ctl   <= ctl_in;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: table-driven operand vectors, hand-written multi-cycle
// sequences and a randomized run, all checked cycle by cycle against a
// behavioural model of the decode stage (integer counters per register).
module tb_id_stage_pipe;

  localparam int DATA_W  = 16;
  localparam int REG_CNT = 8;
  localparam int ADDR_W  = 3;
  localparam int CTL_W   = 8;
  localparam int PEND_W  = 2;
  localparam int PMAX    = (1 << PEND_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              in_valid, in_ready;
  logic [ADDR_W-1:0] rs_addr, rt_addr, rd_addr;
  logic              use_rs, use_rt, rf_wr;
  logic [DATA_W-1:0] imm;
  logic              immregsel, inv_src0, inv_src1;
  logic [CTL_W-1:0]  ctl_in;
  logic              wb_wr;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush, ex_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_src0, out_src1, out_store;
  logic [ADDR_W-1:0] out_rd;
  logic              out_rf_wr;
  logic [CTL_W-1:0]  out_ctl;
  logic              err;

  id_stage_pipe #(
    .DATA_W(DATA_W), .REG_CNT(REG_CNT), .ADDR_W(ADDR_W),
    .CTL_W(CTL_W), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .use_rs(use_rs), .use_rt(use_rt), .rf_wr(rf_wr),
    .imm(imm), .immregsel(immregsel), .inv_src0(inv_src0), .inv_src1(inv_src1),
    .ctl_in(ctl_in),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready),
    .out_valid(out_valid), .out_src0(out_src0), .out_src1(out_src1),
    .out_store(out_store), .out_rd(out_rd), .out_rf_wr(out_rf_wr),
    .out_ctl(out_ctl), .err(err)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_rf [REG_CNT];
  int                m_pend [REG_CNT];
  bit                m_ov, m_orfwr, m_err;
  logic [DATA_W-1:0] m_src0, m_src1, m_store;
  logic [ADDR_W-1:0] m_rd;
  logic [CTL_W-1:0]  m_ctl;
  bit                m_free, m_ready, m_acc;
  logic [DATA_W-1:0] m_n0, m_n1, m_nst;

  function automatic int pend_of(input int a);
    return (a < REG_CNT) ? m_pend[a] : 0;
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input int a);
    if (a >= REG_CNT) return '0;
`ifdef ID_WB_BYPASS_EN
    if (wb_wr && int'(wb_addr) == a) return wb_data;
`endif
    return m_rf[a];
  endfunction

  // Writers still outstanding once this cycle's writeback (if forwarded) lands.
  function automatic bit is_busy(input bit use_it, input int a);
    int outstanding;
    if (!use_it) return 1'b0;
    outstanding = pend_of(a);
`ifdef ID_WB_BYPASS_EN
    if (wb_wr && int'(wb_addr) == a) outstanding--;
`endif
    return outstanding > 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < REG_CNT; r++) begin
      m_rf[r]   = '0;
      m_pend[r] = 0;
    end
    m_ov = 0; m_orfwr = 0; m_err = 0;
    m_src0 = '0; m_src1 = '0; m_store = '0; m_rd = '0; m_ctl = '0;
  endtask

  task automatic model_comb();
    bit haz;
    logic [DATA_W-1:0] v0, v1, sel;
    haz = is_busy(use_rs, int'(rs_addr)) || is_busy(use_rt, int'(rt_addr)) ||
          (rf_wr && pend_of(int'(rd_addr)) == PMAX && !(wb_wr && wb_addr == rd_addr));
    m_free  = !m_ov || ex_ready;
    m_ready = m_free && !haz && !flush;
    m_acc   = in_valid && m_ready;
    v0    = read_reg(int'(rs_addr));
    v1    = read_reg(int'(rt_addr));
    sel   = immregsel ? imm : v1;
    m_n0  = inv_src0 ? ~v0 : v0;
    m_n1  = inv_src1 ? ~sel : sel;
    m_nst = v1;
  endtask

  task automatic model_edge();
    int np [REG_CNT];
    if (rst) begin
      model_reset();
      return;
    end
    for (int r = 0; r < REG_CNT; r++) begin
      np[r] = m_pend[r];
      if (m_acc && rf_wr && int'(rd_addr) == r) np[r]++;
      if (wb_wr && int'(wb_addr) == r) np[r]--;
      if (flush && m_ov && m_orfwr && int'(m_rd) == r) np[r]--;
      if (np[r] < 0) np[r] = 0;
    end
    if (wb_wr) begin
      if (int'(wb_addr) >= REG_CNT) m_err = 1;
      else if (m_pend[int'(wb_addr)] == 0 && !(m_acc && rf_wr && rd_addr == wb_addr)) m_err = 1;
    end
    if (wb_wr && int'(wb_addr) < REG_CNT) m_rf[int'(wb_addr)] = wb_data;
    if (flush) begin
      m_ov = 0;
    end else if (m_free) begin
      m_ov = m_acc;
      if (m_acc) begin
        m_src0 = m_n0; m_src1 = m_n1; m_store = m_nst;
        m_rd = rd_addr; m_orfwr = rf_wr; m_ctl = ctl_in;
      end
    end
    for (int r = 0; r < REG_CNT; r++) m_pend[r] = np[r];
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_ov);
    chk("out_src0",  out_src0,  m_src0);
    chk("out_src1",  out_src1,  m_src1);
    chk("out_store", out_store, m_store);
    chk("out_rd",    out_rd,    m_rd);
    chk("out_rf_wr", out_rf_wr, m_orfwr);
    chk("out_ctl",   out_ctl,   m_ctl);
    chk("err",       err,       m_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 0; rs_addr = '0; rt_addr = '0; rd_addr = '0;
    use_rs = 0; use_rt = 0; rf_wr = 0; imm = '0; immregsel = 0;
    inv_src0 = 0; inv_src1 = 0; ctl_in = '0;
    wb_wr = 0; wb_addr = '0; wb_data = '0; flush = 0; ex_ready = 1;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #2;
    model_comb();
    chk("in_ready", in_ready, m_ready);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  // ---------------- operand vector table ----------------
  typedef struct {
    logic [ADDR_W-1:0] rs, rt;
    logic              isel, inv0, inv1;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] e0, e1, es;
  } op_vec_t;
  op_vec_t vecs [6];

  int cand [$];

  initial begin
    // r2 = 0x00FF and r3 = 0x1234 are loaded by the directed sequences below.
    vecs[0] = '{rs:3'd3, rt:3'd2, isel:0, inv0:0, inv1:0, imm:16'h0000, e0:16'h1234, e1:16'h00FF, es:16'h00FF};
    vecs[1] = '{rs:3'd0, rt:3'd3, isel:1, inv0:0, inv1:1, imm:16'h0005, e0:16'h0000, e1:16'hFFFA, es:16'h1234};
    vecs[2] = '{rs:3'd0, rt:3'd0, isel:0, inv0:1, inv1:0, imm:16'h0000, e0:16'hFFFF, e1:16'h0000, es:16'h0000};
    vecs[3] = '{rs:3'd2, rt:3'd3, isel:0, inv0:1, inv1:1, imm:16'h0000, e0:16'hFF00, e1:16'hEDCB, es:16'h1234};
    vecs[4] = '{rs:3'd3, rt:3'd2, isel:1, inv0:0, inv1:0, imm:16'hBEEF, e0:16'h1234, e1:16'hBEEF, es:16'h00FF};
    vecs[5] = '{rs:3'd7, rt:3'd7, isel:0, inv0:1, inv1:0, imm:16'h0000, e0:16'hFFFF, e1:16'h0000, es:16'h0000};

    idle_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Reset state.
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_out_src0", out_src0, '0);
    #2 chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Writer of r3, then writeback 0x1234, then a reader of r3.
    in_valid = 1; rf_wr = 1; rd_addr = 3'd3;
    cycle();
    in_valid = 0; rf_wr = 0; wb_wr = 1; wb_addr = 3'd3; wb_data = 16'h1234;
    cycle();
    wb_wr = 0; in_valid = 1; use_rs = 1; rs_addr = 3'd3;
    cycle();
    chk("wb_read_src0", out_src0, 16'h1234);
    chk("wb_read_valid", out_valid, 1'b1);
    chk("wb_read_err", err, 1'b0);

    // RAW hazard on r2 resolved by writeback.
    idle_inputs();
    in_valid = 1; rf_wr = 1; rd_addr = 3'd2;
    cycle();
    idle_inputs();
    in_valid = 1; use_rt = 1; rt_addr = 3'd2;
    for (int i = 0; i < 2; i++) begin
      #2 chk("raw_stall", in_ready, 1'b0);
      cycle();
    end
    wb_wr = 1; wb_addr = 3'd2; wb_data = 16'h00FF;
`ifdef ID_WB_BYPASS_EN
    #2 chk("raw_bypass_ready", in_ready, 1'b1);
    cycle();
    wb_wr = 0;
`else
    #2 chk("raw_wb_cycle_ready", in_ready, 1'b0);
    cycle();
    wb_wr = 0;
    #2 chk("raw_after_wb_ready", in_ready, 1'b1);
    cycle();
`endif
    chk("raw_src1", out_src1, 16'h00FF);
    chk("raw_valid", out_valid, 1'b1);

    // Operand formation table.
    for (int v = 0; v < 6; v++) begin
      idle_inputs();
      in_valid = 1; use_rs = 1; use_rt = 1;
      rs_addr = vecs[v].rs; rt_addr = vecs[v].rt; immregsel = vecs[v].isel;
      inv_src0 = vecs[v].inv0; inv_src1 = vecs[v].inv1; imm = vecs[v].imm;
      cycle();
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_src0", out_src0, vecs[v].e0);
      chk("vec_src1", out_src1, vecs[v].e1);
      chk("vec_store", out_store, vecs[v].es);
    end

    // EX back-pressure: X held for 3 cycles, then Y loads.
    idle_inputs();
    in_valid = 1; immregsel = 1; imm = 16'h0042; ctl_in = 8'h5A;
    cycle();
    imm = 16'h0077; ctl_in = 8'h3C; ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("stall_ready", in_ready, 1'b0);
      cycle();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_src1", out_src1, 16'h0042);
      chk("stall_ctl", out_ctl, 8'h5A);
    end
    ex_ready = 1;
    cycle();
    chk("release_src1", out_src1, 16'h0077);
    chk("release_ctl", out_ctl, 8'h3C);

    // Flush a held writer of r5; a reader of r5 must then pass.
    idle_inputs();
    in_valid = 1; rf_wr = 1; rd_addr = 3'd5;
    cycle();
    idle_inputs();
    ex_ready = 0; flush = 1;
    cycle();
    chk("flush_valid", out_valid, 1'b0);
    idle_inputs();
    in_valid = 1; use_rs = 1; rs_addr = 3'd5;
    #2 chk("flush_reader_ready", in_ready, 1'b1);
    cycle();
    chk("flush_reader_valid", out_valid, 1'b1);

    // Unexpected writeback sets a sticky error.
    idle_inputs();
    wb_wr = 1; wb_addr = 3'd6; wb_data = 16'hDEAD;
    cycle();
    chk("err_set", err, 1'b1);
    wb_wr = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("err_sticky", err, 1'b1);
    end
    rst = 1;
    cycle();
    rst = 0;
    chk("err_cleared", err, 1'b0);
    chk("rst2_valid", out_valid, 1'b0);

    // Pending counter saturation on r1.
    idle_inputs();
    in_valid = 1; rf_wr = 1; rd_addr = 3'd1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("sat_accept", in_ready, 1'b1);
      cycle();
    end
    #2 chk("sat_full", in_ready, 1'b0);
    cycle();
    wb_wr = 1; wb_addr = 3'd1; wb_data = 16'h0101;
    #2 chk("sat_wb_frees", in_ready, 1'b1);
    cycle();
    in_valid = 0;
    repeat (3) cycle();
    wb_wr = 0;
    cycle();
    chk("sat_drain_err", err, 1'b0);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      rs_addr   = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      rt_addr   = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      rd_addr   = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      use_rs    = $urandom_range(0, 1);
      use_rt    = $urandom_range(0, 1);
      rf_wr     = $urandom_range(0, 1);
      imm       = DATA_W'($urandom);
      immregsel = $urandom_range(0, 1);
      inv_src0  = $urandom_range(0, 1);
      inv_src1  = $urandom_range(0, 1);
      ctl_in    = CTL_W'($urandom);
      ex_ready  = ($urandom_range(0, 99) < 75);
      flush     = ($urandom_range(0, 99) < 5);
      rst       = ($urandom_range(0, 999) < 8);
      wb_data   = DATA_W'($urandom);
      wb_wr     = 0;
      wb_addr   = '0;
      cand.delete();
      for (int r = 0; r < REG_CNT; r++) if (m_pend[r] > 0) cand.push_back(r);
      if ($urandom_range(0, 99) < 45 && cand.size() > 0) begin
        wb_wr   = 1;
        wb_addr = ADDR_W'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 99) < 2) begin
        wb_wr   = 1;
        wb_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      end
      cycle();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
